// File: rtl/sram_boot_arbiter.sv
// Boot sequencer (IDLE->INIT->LOAD->RUN) and single-port SRAM arbiter for init engine, host loader and core.
// Latency: grant is combinational in the request cycle; read data/rvalid return one cycle after the grant.
// Backpressure: host holds its request until host_gnt (core wins in RUN); core accesses outside RUN are dropped.
module sram_boot_arbiter #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_boot_start,
  output logic          o_init_start,
  input  logic          i_init_done,
  input  logic          i_init_en,
  input  logic          i_init_wr,
  input  logic [AW-1:0] i_init_addr,
  input  logic [DW-1:0] i_init_wdata,
  input  logic          i_host_req,
  input  logic          i_host_wr,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  input  logic          i_host_load_done,
  input  logic          i_core_en,
  input  logic          i_core_wr,
  input  logic [AW-1:0] i_core_addr,
  input  logic [DW-1:0] i_core_wdata,
  output logic          o_core_rvalid,
  output logic [DW-1:0] o_core_rdata,
  output logic          o_core_run,
  output logic          o_core_blocked,
  output logic          o_sram_en,
  output logic          o_sram_wr,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_wdata,
  input  logic [DW-1:0] i_sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_init_start;
  logic          r_core_run;
  logic          r_core_blocked;
  logic [1:0]    r_tag;          // {host, core} read issued last cycle

  logic          w_host_gnt;
  logic          w_core_gnt;
  logic          w_sram_en;
  logic          w_sram_wr;
  logic [AW-1:0] w_sram_addr;
  logic [DW-1:0] w_sram_wdata;

  // Boot FSM; init_start/core_run are registered alongside the state so they track it exactly.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_init_start <= 1'b0;
      r_core_run   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_boot_start) begin
          r_state      <= ST_INIT;
          r_init_start <= 1'b1;
        end
        ST_INIT: if (i_init_done) begin
          r_state      <= ST_LOAD;
          r_init_start <= 1'b0;
        end
        ST_LOAD: if (i_host_load_done) begin
          r_state    <= ST_RUN;
          r_core_run <= 1'b1;
        end
        ST_RUN: if (i_boot_start) begin
          r_state      <= ST_INIT;
          r_core_run   <= 1'b0;
          r_init_start <= 1'b1;
        end
      endcase
    end
  end

  // Port ownership from current state: init engine in INIT, host in LOAD, core-over-host in RUN.
  always_comb begin
    w_host_gnt   = 1'b0;
    w_core_gnt   = 1'b0;
    w_sram_en    = 1'b0;
    w_sram_wr    = 1'b0;
    w_sram_addr  = '0;
    w_sram_wdata = '0;
    case (r_state)
      ST_INIT: begin
        w_sram_en    = i_init_en;
        w_sram_wr    = i_init_wr;
        w_sram_addr  = i_init_addr;
        w_sram_wdata = i_init_wdata;
      end
      ST_LOAD: w_host_gnt = i_host_req;
      ST_RUN: begin
        w_core_gnt = i_core_en;
        w_host_gnt = i_host_req & ~i_core_en;
      end
      default: ;
    endcase
    if (w_core_gnt) begin
      w_sram_en    = 1'b1;
      w_sram_wr    = i_core_wr;
      w_sram_addr  = i_core_addr;
      w_sram_wdata = i_core_wdata;
    end else if (w_host_gnt) begin
      w_sram_en    = 1'b1;
      w_sram_wr    = i_host_wr;
      w_sram_addr  = i_host_addr;
      w_sram_wdata = i_host_wdata;
    end
  end

  // Read tag steers next-cycle rvalid; it is not gated by state so a last-RUN-cycle read still returns.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tag <= 2'b00;
    end else begin
      r_tag <= {w_host_gnt & ~i_host_wr, w_core_gnt & ~i_core_wr};
    end
  end

  // Sticky flag for core accesses attempted before the core was released; only reset clears it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_core_blocked <= 1'b0;
    end else if (i_core_en && (r_state != ST_RUN)) begin
      r_core_blocked <= 1'b1;
    end
  end

  assign o_init_start   = r_init_start;
  assign o_core_run     = r_core_run;
  assign o_core_blocked = r_core_blocked;
  assign o_host_gnt     = w_host_gnt;
  assign o_host_rvalid  = r_tag[1];
  assign o_core_rvalid  = r_tag[0];
  assign o_host_rdata   = i_sram_rdata;
  assign o_core_rdata   = i_sram_rdata;
  assign o_sram_en      = w_sram_en;
  assign o_sram_wr      = w_sram_wr;
  assign o_sram_addr    = w_sram_addr;
  assign o_sram_wdata   = w_sram_wdata;

endmodule
